// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The master raises start for one cycle to request an operation; it is
// accepted only while busy is low. busy then stays high until hi/lo hold
// the final result.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MIPS-style mult/multu/div/divu with HI/LO registers.
// One 64-bit working register is shared by the shift-add and the restoring-division datapaths.
module muldiv_unit (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic        neg_q;
  logic        neg_r;
  logic        div0;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        is_div;
  logic [32:0] add_sum;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] rem_sub;
  logic [63:0] acc_step;
  logic [63:0] prod;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  always_comb begin
    sgn   = ~bus.op[0];
    abs_a = (sgn && bus.a[31]) ? 32'd0 - bus.a : bus.a;
    abs_b = (sgn && bus.b[31]) ? 32'd0 - bus.b : bus.b;
  end

  // Mult: acc = {partial, multiplier}, add opnd when the low bit is set, then shift right.
  // Div:  acc = {remainder, dividend}, shift left and subtract opnd when it fits.
  always_comb begin
    is_div  = op_r[1];
    add_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    sh      = {acc[63:32], acc[31]};
    ge      = (sh >= {1'b0, opnd});
    rem_sub = sh[31:0] - opnd;
    if (is_div)
      acc_step = ge ? {rem_sub, acc[30:0], 1'b1} : {sh[31:0], acc[30:0], 1'b0};
    else
      acc_step = {add_sum, acc[31:1]};
  end

  // Sign correction happens only once, on the edge that retires the operation.
  always_comb begin
    prod   = neg_q ? 64'd0 - acc_step : acc_step;
    q      = acc_step[31:0];
    r      = acc_step[63:32];
    fin_lo = prod[31:0];
    fin_hi = prod[63:32];
    if (is_div) begin
      fin_lo = div0 ? 32'hFFFF_FFFF : (neg_q ? 32'd0 - q : q);
      fin_hi = neg_r ? 32'd0 - r : r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      op_r  <= 2'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      acc   <= 64'd0;
      opnd  <= 32'd0;
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= 5'd0;
            op_r  <= bus.op;
            neg_q <= sgn & (bus.a[31] ^ bus.b[31]);
            neg_r <= sgn & bus.a[31];
            div0  <= (bus.b == 32'd0);
            if (bus.op[1]) begin
              acc  <= {32'd0, abs_a};
              opnd <= abs_b;
            end else begin
              acc  <= {32'd0, abs_b};
              opnd <= abs_a;
            end
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        default: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= IDLE;
            hi_r  <= fin_hi;
            lo_r  <= fin_lo;
          end
        end
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random bench for muldiv_unit: expected HI/LO are queued at
// issue and popped when busy falls.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  muldiv_unit_if bus ();

  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sp;
    logic [63:0] up;
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        hi = sp[63:32]; lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 32'd0; end
        else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
      end
      default: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Issue one operation; optionally try moves at T0 and an intruding start+mthi at cycle 5.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic mv_at_t0, input logic intrude);
    int cycles;
    logic [31:0] ghi, glo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.mthi = mv_at_t0; bus.mtlo = mv_at_t0; bus.wdata = 32'hDEAD_BEEF;
    exp_hi_q.push_back(ehi);
    exp_lo_q.push_back(elo);
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      if (intrude && cycles == 5) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd2;
        bus.mthi = 1'b1; bus.wdata = 32'd5;
      end else begin
        bus.start = 1'b0; bus.mthi = 1'b0;
      end
      if (cycles == 16) begin
        check({tag, " hi_hold"}, bus.hi, cur_hi);
        check({tag, " lo_hold"}, bus.lo, cur_lo);
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.mthi = 1'b0;
    check({tag, " busy_cycles"}, 32'(cycles), 32'd32);
    ghi = exp_hi_q.pop_front();
    glo = exp_lo_q.pop_front();
    check({tag, " hi"}, bus.hi, ghi);
    check({tag, " lo"}, bus.lo, glo);
    cur_hi = ghi; cur_lo = glo;
  endtask

  task automatic move(input string tag, input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    bus.mthi = h; bus.mtlo = l; bus.wdata = d;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    if (h) cur_hi = d;
    if (l) cur_lo = d;
    check({tag, " hi"}, bus.hi, cur_hi);
    check({tag, " lo"}, bus.lo, cur_lo);
  endtask

  initial begin
    logic [31:0] ra, rb, mh, ml;
    logic [1:0] rop;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset state", 32'(bus.dbg_state), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    rst = 1'b0;

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    do_op("mult_neg", 2'b00, -32'sd7, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    do_op("div_neg", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    do_op("div_rem_sign", 2'b10, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 1'b0);

    move("mthi_only", 1'b1, 1'b0, 32'h1234_5678);
    move("mtlo_only", 1'b0, 1'b1, 32'h9ABC_DEF0);
    move("mthi_mtlo", 1'b1, 1'b1, 32'h0BAD_CAFE);

    do_op("start_with_move", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);
    do_op("divu_intrude", 2'b11, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i[0]) ? $urandom : 32'($urandom_range(1, 300)));
      model(rop, ra, rb, mh, ml);
      do_op("random", rop, ra, rb, mh, ml, 1'b0, 1'b0);
    end

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_run busy", 32'(bus.busy), 32'd0);
    check("rst_run hi", bus.hi, 32'd0);
    check("rst_run lo", bus.lo, 32'd0);
    cur_hi = 32'd0; cur_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    move("post_rst_mtlo", 1'b0, 1'b1, 32'd9);
    do_op("post_rst_multu", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);
    check("idle_state", 32'(bus.dbg_state), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, with ports named as follows.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on a rising edge of clk.
REQ-005 op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a  input  32  operand A (rs value, already forwarded in EX).
REQ-007 b  input  32  operand B (rt value, already forwarded in EX).
REQ-008 mthi  input  1  write wdata to HI.
REQ-009 mtlo  input  1  write wdata to LO.
REQ-010 wdata  input  32  data for mthi/mtlo.
REQ-011 busy  output  1  operation in progress; the hazard unit uses it to stall mfhi/mflo/mult/div in ID.
REQ-012 hi  output  32  HI register.
REQ-013 lo  output  32  LO register.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN; busy SHALL be 1 exactly when the state is RUN.
REQ-015 In IDLE, start=1 at an edge SHALL latch op, a and b; latch cnt=0; enter RUN. This edge is called T0.
REQ-016 RUN SHALL last exactly 32 cycles; cnt is 5 bits and increments once per cycle.
REQ-017 The edge at cnt=31 (T32) SHALL write the final HI/LO, return the FSM to IDLE and deassert busy.
REQ-018 hi/lo SHALL hold their previous values from T0 until T32; no partial results are visible.
REQ-019 mult/multu SHALL use a shift-add datapath, one bit per cycle, producing a 64-bit product {HI,LO}.
REQ-020 Signed mult SHALL operate on magnitudes and negate the 64-bit product if a[31]^b[31].
REQ-021 div/divu SHALL use restoring division, one quotient bit per cycle, with LO=quotient and HI=remainder.
REQ-022 Signed div SHALL truncate the quotient toward zero; the remainder SHALL take the sign of a.
REQ-023 Divide by zero (b=0) SHALL give LO=32'hFFFF_FFFF and HI=a, for both signed and unsigned.
REQ-024 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL give LO=32'h8000_0000 and HI=0.
REQ-025 start while busy=1 SHALL be ignored; the operation in flight continues unchanged.
REQ-026 mthi/mtlo in IDLE SHALL write at that edge; the new value is visible on hi/lo in the next cycle.
REQ-027 mthi/mtlo while busy=1 SHALL be ignored.
REQ-028 start together with mthi/mtlo in IDLE: start SHALL take effect and the moves SHALL be discarded.
REQ-029 mthi and mtlo together in IDLE SHALL write both registers.
REQ-030 Operand changes on a/b after T0 SHALL have no effect on the result.
REQ-031 The block SHALL produce no overflow flag and no exception.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, busy=0, hi=0, lo=0, cnt=0, all internal datapath registers 0.
REQ-033 rst asserted during RUN SHALL abort the operation; hi/lo SHALL read 0 and not the partial result.
REQ-034 After rst is released, the first start at a rising edge SHALL be accepted normally.

Verification
REQ-035 multu a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> busy high for 32 cycles; then hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-036 mult a=-7, b=3 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-037 div a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; divu a=100, b=0 -> lo=32'hFFFF_FFFF, hi=100.
REQ-038 div a=32'h8000_0000, b=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
REQ-039 Start divu 10/3; at cycle 5 pulse start (mult 2,2) plus mthi wdata=5 -> both ignored; final hi=1, lo=3, busy low after exactly 32 cycles.
REQ-040 Start multu 6*7; assert rst at cycle 10 -> busy=0, hi=lo=0 asynchronously; after release, mtlo wdata=9 -> lo=9 next cycle.
